// File: rtl/arith_pkg.sv
// Shared constants for the arithmetic datapath: default operand width,
// iteration counter width and the multiplier FSM state encoding.
package arith_pkg;

  // Operand width of the datapath; tied to the 4-bit ripple-carry adder.
  localparam int DEFAULT_WIDTH = 4;

  // Iteration counter width; 2**DEFAULT_CNT_W must exceed the operand width.
  localparam int DEFAULT_CNT_W = 3;

  // Multiplier FSM states. Encoding 2'd3 is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/shift_add_multiplier_adder.sv
// 4-bit ripple-carry adder: the single adder used by the shift-add loop.
module shift_add_multiplier_adder (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       cout_o
);

  logic carry;

  // Chain four full adders from bit 0 upwards; the final carry is Cout.
  always_comb begin
    carry = cin_i;
    sum_o = '0;
    for (int i = 0; i < 4; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
      carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
    end
    cout_o = carry;
  end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier. One adder, WIDTH iterations.
// A start strobe in IDLE captures A/B; after WIDTH RUN cycles the product is
// registered on entry to DONE, where done pulses for one cycle.
//
// Handshake: start is a request sampled on the rising edge and accepted only
// while busy is low (IDLE). There is no back-pressure on the result: done is a
// single-cycle pulse and Product holds until the next accepted start finishes.
module shift_add_multiplier
  import arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] Product,
  output logic [1:0]         dbg_state_o
);

  mul_state_e state_q, state_d;

  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   acc_hi_q;
  logic [WIDTH-1:0]   acc_lo_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] product_q;

  logic [WIDTH-1:0]   adder_b;
  logic [WIDTH-1:0]   adder_sum;
  logic               adder_cout;
  logic [2*WIDTH-1:0] shifted;
  logic               last_iter;

  // Multiplier bit gates the multiplicand; an explicit zero keeps X out.
  assign adder_b = acc_lo_q[0] ? mcand_q : '0;

  shift_add_multiplier_adder u_adder (
    .a_i    (acc_hi_q),
    .b_i    (adder_b),
    .cin_i  (1'b0),
    .sum_o  (adder_sum),
    .cout_o (adder_cout)
  );

  // Right shift of the (WIDTH+1)-bit partial sum into the low half; the LSB
  // of acc_lo (the multiplier bit just consumed) drops off. Cout is kept.
  assign shifted   = {adder_cout, adder_sum, acc_lo_q[WIDTH-1:1]};
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; DONE always returns to IDLE, illegal code recovers.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_iter) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs decoded from the current state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      RUN:  busy = 1'b1;
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Datapath: load operands on accept, shift-add during RUN, latch product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q   <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            mcand_q  <= A;
            acc_lo_q <= B;
            acc_hi_q <= '0;
            cnt_q    <= '0;
          end
        end
        RUN: begin
          acc_hi_q <= shifted[2*WIDTH-1:WIDTH];
          acc_lo_q <= shifted[WIDTH-1:0];
          cnt_q    <= cnt_q + CNT_W'(1);
          if (last_iter) product_q <= shifted;
        end
        default: begin
          mcand_q <= mcand_q;
        end
      endcase
    end
  end

  assign Product     = product_q;
  assign dbg_state_o = state_q;

endmodule
